branch_resolve_unit: RTL

Parametrised successor to the ID-stage register-equality comparator used for early branch resolution. Evaluates a full MIPS branch condition set on two WIDTH-bit operands and registers the outcome. When forwarded operands are not yet available, it waits for them, holding a stall request to the hazard unit, with a bounded wait. Sits in the ID stage between the forwarding muxes and the PC-select / IF-flush logic.

---
 rtl/branch_resolve_unit.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit for the ID stage.
// Evaluates BEQ/BNE/BLEZ/BGTZ/BLTZ/BGEZ on the forwarded operands and
// registers the outcome as a one-cycle result pulse. When a needed operand
// is not yet forwarded it parks in WAIT, raising stall to the hazard unit,
// and gives up with err=1 after MAX_WAIT cycles in WAIT.
// Optional macro BRANCH_STATS_EN adds saturating taken / not-taken /
// timeout counters (CNT_W bits wide).
module branch_resolve_unit #(
   parameter int WIDTH    = 32,
   parameter int MAX_WAIT = 3
`ifdef BRANCH_STATS_EN
   ,
   parameter int CNT_W    = 16
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   input  logic             rs_ready,
   input  logic             rt_ready,
   input  logic             flush,
   output logic             stall,
   output logic             res_valid,
   output logic             taken,
   output logic             equal,
   output logic             err,
   output logic             busy
`ifdef BRANCH_STATS_EN
   ,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] nottaken_cnt,
   output logic [CNT_W-1:0] timeout_cnt
`endif
);

   localparam logic [2:0] OP_BEQ  = 3'd0;
   localparam logic [2:0] OP_BNE  = 3'd1;
   localparam logic [2:0] OP_BLEZ = 3'd2;
   localparam logic [2:0] OP_BGTZ = 3'd3;
   localparam logic [2:0] OP_BLTZ = 3'd4;
   localparam logic [2:0] OP_BGEZ = 3'd5;

   // The wait counter only has to reach MAX_WAIT-1.
   localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
   localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

   typedef enum logic {
      S_IDLE,
      S_WAIT
   } state_t;

   state_t        state;
   logic [2:0]    latchedOp;
   logic [CW-1:0] waitCnt;

   logic [2:0] curOp;
   logic       needRt;
   logic       opsOk;
   logic       illegalOp;
   logic       rsZero;
   logic       rsNeg;
   logic       isEqual;
   logic       condTaken;
   logic       idleGo;
   logic       waitGo;
   logic       resolveGood;
   logic       resolveIllegal;
   logic       resolveTimeout;
   logic       enterWait;

   // Decode the active op (latched while waiting), evaluate the branch
   // condition and classify what this cycle does to the state machine.
   always_comb begin
      curOp          = (state == S_WAIT) ? latchedOp : op;
      needRt         = (curOp == OP_BEQ) || (curOp == OP_BNE);
      opsOk          = rs_ready && (rt_ready || !needRt);
      illegalOp      = (curOp[2] && curOp[1]);
      rsZero         = (rs_data == '0);
      rsNeg          = rs_data[WIDTH-1];
      isEqual        = (rs_data == rt_data);
      condTaken      = 1'b0;
      case (curOp)
         OP_BEQ:  condTaken = isEqual;
         OP_BNE:  condTaken = !isEqual;
         OP_BLEZ: condTaken = rsNeg || rsZero;
         OP_BGTZ: condTaken = !rsNeg && !rsZero;
         OP_BLTZ: condTaken = rsNeg;
         OP_BGEZ: condTaken = !rsNeg;
         default: condTaken = 1'b0;
      endcase
      idleGo         = (state == S_IDLE) && req_valid && !flush;
      waitGo         = (state == S_WAIT) && !flush;
      resolveGood    = (idleGo && !illegalOp && opsOk) || (waitGo && opsOk);
      resolveIllegal = idleGo && illegalOp;
      resolveTimeout = waitGo && !opsOk && (waitCnt == LAST_WAIT);
      enterWait      = idleGo && !illegalOp && !opsOk;
      stall          = !flush &&
                       (((state == S_IDLE) && req_valid && !illegalOp && !opsOk) ||
                        ((state == S_WAIT) && !opsOk));
   end

   // Main state machine with registered result outputs; results are pulses
   // and every qualifier falls back to zero when no result is presented.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         latchedOp <= 3'd0;
         waitCnt   <= '0;
         res_valid <= 1'b0;
         taken     <= 1'b0;
         equal     <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
      end else begin
         res_valid <= 1'b0;
         taken     <= 1'b0;
         equal     <= 1'b0;
         err       <= 1'b0;
         if (resolveGood) begin
            res_valid <= 1'b1;
            taken     <= condTaken;
            equal     <= isEqual;
            state     <= S_IDLE;
            busy      <= 1'b0;
         end else if (resolveIllegal || resolveTimeout) begin
            res_valid <= 1'b1;
            err       <= 1'b1;
            equal     <= isEqual;
            state     <= S_IDLE;
            busy      <= 1'b0;
         end else if (enterWait) begin
            state     <= S_WAIT;
            latchedOp <= op;
            waitCnt   <= '0;
            busy      <= 1'b1;
         end else if (state == S_WAIT) begin
            if (flush) begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end else begin
               waitCnt <= waitCnt + 1'b1;
            end
         end
      end
   end

`ifdef BRANCH_STATS_EN
   // Saturating statistics, bumped on the same edge that registers a result;
   // illegal-op results are deliberately not counted.
   always_ff @(posedge clk) begin
      if (reset) begin
         taken_cnt    <= '0;
         nottaken_cnt <= '0;
         timeout_cnt  <= '0;
      end else begin
         if (resolveGood && condTaken && (taken_cnt != '1))
            taken_cnt <= taken_cnt + 1'b1;
         if (resolveGood && !condTaken && (nottaken_cnt != '1))
            nottaken_cnt <= nottaken_cnt + 1'b1;
         if (resolveTimeout && (timeout_cnt != '1))
            timeout_cnt <= timeout_cnt + 1'b1;
      end
   end
`endif

endmodule
